dmem_bus: RTL and testbench
===========================

// Module: dmem_bus
// PURPOSE
//   Data-memory subsystem on the datapath's dmem port: decodes dmem_addr into word RAM or MMIO UART.
//   Read data is combinational for the single-cycle core. Writes commit on the rising clk edge.
//   The UART transmitter is 8N1, fed by a TX FIFO, with a programmable baud divider.
// PARAMETERS
//   XLEN          32    data/address width
//   RAM_AW        10    RAM word-address bits (2^RAM_AW words at byte 0x0000_0000)
//   FIFO_AW       3     TX FIFO address bits (depth 2^FIFO_AW = 8)
//   CLKS_PER_BIT  16    reset value of BAUD_DIV
// PORTS
//   clk         in   1     clock; all state updates on rising edge
//   reset       in   1     synchronous, active-high
//   dmem_addr   in   XLEN  byte address from datapath
//   dmem_wdata  in   XLEN  store data, lane-aligned by the datapath
//   dmem_we     in   1     write strobe, one cycle per store
//   dmem_rdata  out  XLEN  read data, combinational from dmem_addr
//   uart_tx     out  1     serial line, idle high, registered
// BEHAVIOUR
//   Address map (word-aligned; dmem_addr[1:0] ignored):
//     0x0000_0000 + 4*i  RAM[i], i < 2^RAM_AW. R/W, full-word write.
//     0x8000_0000 TXDATA   W: push wdata[7:0] into FIFO. R: 0.
//     0x8000_0004 STATUS   R: {.., cnt[FIFO_AW:0] @[8+:], ovf@3, busy@2, empty@1, full@0}.
//                          W (any data): clear ovf.
//     0x8000_0008 BAUD_DIV R/W [15:0]. Value 0 behaves as 1.
//     Other addresses: read 0; writes ignored.
//   Reads have no side effects. dmem_rdata is valid even when dmem_we=0.
//   Reset state:
//     uart_tx=1, FIFO empty (cnt=0), ovf=0, FSM=IDLE, BAUD_DIV=CLKS_PER_BIT.
//     RAM contents are not reset. dmem_rdata follows the map with these values.
//   FIFO push:
//     A TXDATA write is accepted iff cnt != DEPTH before the edge.
//     A pop in the same cycle does not free space for that push.
//     A rejected push drops the byte and sets ovf (sticky).
//     Simultaneous push+pop with 0 < cnt < DEPTH leaves cnt unchanged.
//     Pointers wrap modulo DEPTH.
//   TX FSM (bit period P = max(BAUD_DIV,1) clks; baud counter counts P-1..0):
//     IDLE:  if !empty, pop head into shift reg, uart_tx<=0, go START.
//            A byte pushed at edge N starts (tx low) after edge N+1.
//     START: after P cycles, uart_tx<=bit0, go DATA, bit_idx=0.
//     DATA:  each P cycles shift out the next bit, LSB first.
//            After bit7's P cycles, uart_tx<=1, go STOP.
//     STOP:  after P cycles, if !empty pop and go START back-to-back (no idle gap);
//            else go IDLE.
//     busy = (FSM != IDLE).
//   A BAUD_DIV write mid-frame takes effect at the next bit boundary (counter reload).
//   Reset mid-frame aborts immediately: uart_tx=1 the next cycle, and FIFO contents are lost.
// TESTING
//   1 Reset; read STATUS -> 0x0000_0002. Read BAUD_DIV -> 16. uart_tx=1.
//   2 Write RAM[0x40]=0xDEADBEEF, write RAM[0x44]=1.
//     Read 0x40 -> 0xDEADBEEF and 0x44 -> 1. Read 0x9000_0000 -> 0.
//   3 BAUD_DIV=4, push 0xA5 -> after 1 cycle uart_tx low for 4 clks, then 1,0,1,0,0,1,0,1
//     (4 clks each), stop high 4 clks, then busy=0.
//   4 BAUD_DIV=2, push 0x01,0x02 in consecutive cycles -> frames back-to-back, no idle gap.
//     STATUS empty=1 after the second pop.
//   5 BAUD_DIV=100, push 10 bytes -> 1 pops immediately, 8 queued, 1 dropped:
//     STATUS.full=1, ovf=1. Write STATUS -> ovf=0, full still 1.
//   6 Mid-DATA assert reset 1 cycle -> next cycle uart_tx=1, STATUS=0x2, BAUD_DIV=16.

Source files
------------

// File: rtl/dmem_bus.sv
// Data-memory subsystem: word RAM plus an MMIO UART transmitter (8N1) fed by a TX FIFO.
// Read data is combinational from the address; every write commits on the rising clock edge.
module dmem_bus #(
  parameter int XLEN         = 32,
  parameter int RAM_AW       = 10,
  parameter int FIFO_AW      = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            uart_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [XLEN-1:0]    TXDATA_ADDR = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]    STATUS_ADDR = TXDATA_ADDR + XLEN'(4);
  localparam logic [XLEN-1:0]    BAUD_ADDR   = TXDATA_ADDR + XLEN'(8);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

  logic [XLEN-1:0]    ram [2**RAM_AW];
  logic [7:0]         fifoMem [DEPTH];
  logic [RAM_AW-1:0]  ramIdx;
  logic               ramSel, txdataSel, statusSel, baudSel;
  logic               pushReq, push, pop, full, empty, busy, bitDone;
  logic               unusedAddrBits;
  logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        baud_q, baud_d, reload;
  txState_e           state_q, state_d;
  logic [15:0]        baudCnt_q, baudCnt_d;
  logic [2:0]         bitIdx_q, bitIdx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  // Byte offset within a word is irrelevant to this word-only map.
  assign unusedAddrBits = ^dmem_addr[1:0];

  assign ramIdx    = dmem_addr[RAM_AW+1:2];
  assign ramSel    = (dmem_addr[XLEN-1:RAM_AW+2] == '0);
  assign txdataSel = (dmem_addr[XLEN-1:2] == TXDATA_ADDR[XLEN-1:2]);
  assign statusSel = (dmem_addr[XLEN-1:2] == STATUS_ADDR[XLEN-1:2]);
  assign baudSel   = (dmem_addr[XLEN-1:2] == BAUD_ADDR[XLEN-1:2]);

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign busy    = (state_q != IDLE);
  assign pushReq = dmem_we && txdataSel;
  assign push    = pushReq && !full;
  assign bitDone = (baudCnt_q == '0);
  assign reload  = (baud_q == '0) ? '0 : baud_q - 16'd1;
  assign uart_tx = tx_q;

  always_ff @(posedge clk) begin
    if (dmem_we && ramSel) ram[ramIdx] <= dmem_wdata;
    if (push) fifoMem[wrPtr_q] <= dmem_wdata[7:0];
  end

  // A pop in the same cycle never makes room for a push into a full FIFO.
  always_comb begin
    wrPtr_d = push ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
    cnt_d   = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
    ovf_d = ovf_q;
    if (pushReq && full) ovf_d = 1'b1;
    else if (dmem_we && statusSel) ovf_d = 1'b0;
    baud_d = (dmem_we && baudSel) ? dmem_wdata[15:0] : baud_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      baud_q    <= 16'(CLKS_PER_BIT);
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      baud_q    <= baud_d;
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (bitDone) state_d = DATA;
      DATA:  if (bitDone && bitIdx_q == 3'd7) state_d = STOP;
      STOP:  if (bitDone) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Each bit boundary reloads from the live divider, so divider writes land there.
  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    baudCnt_d = bitDone ? reload : baudCnt_q - 16'd1;
    case (state_q)
      IDLE: begin
        baudCnt_d = reload;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifoMem[rdPtr_q];
          tx_d    = 1'b0;
        end
      end
      START: if (bitDone) begin
        tx_d     = shift_q[0];
        shift_d  = {1'b0, shift_q[7:1]};
        bitIdx_d = '0;
      end
      DATA: if (bitDone) begin
        if (bitIdx_q == 3'd7) begin
          tx_d = 1'b1;
        end else begin
          tx_d     = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
        end
      end
      STOP: if (bitDone && !empty) begin
        pop     = 1'b1;
        shift_d = fifoMem[rdPtr_q];
        tx_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    dmem_rdata = '0;
    if (ramSel) dmem_rdata = ram[ramIdx];
    else if (statusSel) dmem_rdata[FIFO_AW+8:0] = {cnt_q, 4'b0000, ovf_q, busy, empty, full};
    else if (baudSel) dmem_rdata[15:0] = baud_q;
  end

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: RAM access, MMIO decode, UART framing, FIFO overflow and reset abort.
module tb_dmem_bus;

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;
  localparam logic [31:0] BAUD   = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic        uart_tx;
  int          checks = 0;
  int          fails  = 0;

  dmem_bus dut (
    .clk(clk), .reset(reset), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Single-cycle store; returns at the falling edge after the committing rising edge.
  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    dmem_addr = addr; dmem_wdata = data; dmem_we = 1'b1;
    @(negedge clk);
    dmem_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dmem_addr = STATUS; #1; checks++;
    if (dmem_rdata !== 32'h2) begin fails++; $display("[TB] FAIL reset_status got=%h exp=%h", dmem_rdata, 32'h2); end
    dmem_addr = BAUD; #1; checks++;
    if (dmem_rdata !== 32'd16) begin fails++; $display("[TB] FAIL reset_baud got=%h exp=%h", dmem_rdata, 32'd16); end
    checks++;
    if (uart_tx !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx got=%b exp=1", uart_tx); end
  endtask

  task automatic test_ram();
    busWrite(32'h40, 32'hDEADBEEF);
    busWrite(32'h44, 32'h1);
    dmem_addr = 32'h40; #1; checks++;
    if (dmem_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL ram_40 got=%h exp=deadbeef", dmem_rdata); end
    dmem_addr = 32'h47; #1; checks++;
    if (dmem_rdata !== 32'h1) begin fails++; $display("[TB] FAIL ram_44 got=%h exp=1", dmem_rdata); end
    dmem_addr = 32'h9000_0000; #1; checks++;
    if (dmem_rdata !== 32'h0) begin fails++; $display("[TB] FAIL unmapped got=%h exp=0", dmem_rdata); end
    dmem_addr = TXDATA; #1; checks++;
    if (dmem_rdata !== 32'h0) begin fails++; $display("[TB] FAIL txdata_read got=%h exp=0", dmem_rdata); end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    busWrite(BAUD, 32'd4);
    dmem_addr = BAUD; #1; checks++;
    if (dmem_rdata !== 32'd4) begin fails++; $display("[TB] FAIL baud_rw got=%h exp=4", dmem_rdata); end
    busWrite(TXDATA, 32'hA5);
    #1; checks++;
    if (uart_tx !== 1'b1) begin fails++; $display("[TB] FAIL frame_latency got=%b exp=1", uart_tx); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1; checks++;
      if (uart_tx !== frame[k/4]) begin fails++; $display("[TB] FAIL frame_a5 k=%0d got=%b exp=%b", k, uart_tx, frame[k/4]); end
    end
    @(negedge clk);
    dmem_addr = STATUS; #1; checks++;
    if (dmem_rdata !== 32'h2) begin fails++; $display("[TB] FAIL frame_idle got=%h exp=2", dmem_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] frames;
    frames = {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
    busWrite(BAUD, 32'd2);
    @(negedge clk);
    dmem_addr = TXDATA; dmem_wdata = 32'h01; dmem_we = 1'b1;
    @(negedge clk);
    dmem_wdata = 32'h02;
    @(negedge clk);
    dmem_we = 1'b0; dmem_addr = STATUS;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1; checks++;
      if (uart_tx !== frames[k/2]) begin fails++; $display("[TB] FAIL b2b_tx k=%0d got=%b exp=%b", k, uart_tx, frames[k/2]); end
      if (k == 0) begin
        checks++;
        if (dmem_rdata !== 32'h104) begin fails++; $display("[TB] FAIL b2b_status0 got=%h exp=104", dmem_rdata); end
      end
      if (k == 20) begin
        checks++;
        if (dmem_rdata !== 32'h6) begin fails++; $display("[TB] FAIL b2b_empty got=%h exp=6", dmem_rdata); end
      end
    end
    @(negedge clk); #1; checks++;
    if (dmem_rdata !== 32'h2) begin fails++; $display("[TB] FAIL b2b_idle got=%h exp=2", dmem_rdata); end
  endtask

  task automatic test_overflow();
    busWrite(BAUD, 32'd100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dmem_addr = TXDATA; dmem_wdata = 32'(i * 16); dmem_we = 1'b1;
    end
    @(negedge clk);
    dmem_we = 1'b0; dmem_addr = STATUS; #1; checks++;
    if (dmem_rdata !== 32'h80D) begin fails++; $display("[TB] FAIL ovf_set got=%h exp=80d", dmem_rdata); end
    busWrite(STATUS, 32'h0);
    #1; checks++;
    if (dmem_rdata !== 32'h805) begin fails++; $display("[TB] FAIL ovf_clear got=%h exp=805", dmem_rdata); end
  endtask

  task automatic test_reset_abort();
    repeat (150) @(negedge clk);
    #1; checks++;
    if (uart_tx !== 1'b0) begin fails++; $display("[TB] FAIL abort_pre got=%b exp=0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; dmem_addr = STATUS; #1; checks++;
    if (uart_tx !== 1'b1) begin fails++; $display("[TB] FAIL abort_tx got=%b exp=1", uart_tx); end
    checks++;
    if (dmem_rdata !== 32'h2) begin fails++; $display("[TB] FAIL abort_status got=%h exp=2", dmem_rdata); end
    dmem_addr = BAUD; #1; checks++;
    if (dmem_rdata !== 32'd16) begin fails++; $display("[TB] FAIL abort_baud got=%h exp=10", dmem_rdata); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
